rs232_tx: RTL and testbench
===========================

// Module: rs232_tx
// PURPOSE
//  RS232/UART serial transmitter; the transmit-side counterpart of the glitch-filtered receive path.
//  Accepts bytes over a valid/ready handshake and drives the idle-high line: start, 8 data bits LSB-first,
//  optional parity, then 1 or 2 stop bits. Bit period comes from a run-time divisor register, so one
//  build serves any baud rate. Sits between the register/host logic and the tx pad.
// PARAMETERS
//  DIV_W       16   width of baud divisor register
//  DATA_W      8    data bits per frame (fixed 8 in this revision)
// PORTS
//  clk            in   1       system clock (100 MHz nominal, 0.01 us cycle)
//  reset          in   1       synchronous, active-high reset
//  tx_data        in   DATA_W  byte to send; sampled on handshake
//  tx_valid       in   1       tx_data valid
//  tx_ready       out  1       block can accept a byte this cycle
//  r_baud_div     in   DIV_W   bit period = (r_baud_div+1) clk cycles; 0 => 1 cycle/bit
//  r_stop2        in   1       1 = two stop bits, 0 = one
//  r_parity_odd   in   1       1 = odd parity, 0 = even (used only with RS232_TX_PARITY_EN)
//  tx             out  1       serial line, idle high
//  tx_busy        out  1       frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (synchronous, active-high) takes effect on the next clk edge:
//    tx=1, tx_ready=1, tx_busy=0, state=IDLE, counters=0.
//  - Reset mid-frame aborts the frame; tx returns high on that edge. The partial byte is dropped, not resent.
//  - Handshake: a byte is accepted on any edge where tx_valid & tx_ready.
//    On that same edge: tx_data, r_baud_div, r_stop2 and r_parity_odd are latched; state=START; tx<=0.
//  - Register changes after acceptance have no effect on the current frame.
//  - tx_valid without tx_ready: the source holds tx_data stable. The block never drops a byte it did not accept.
//  - FSM: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP(x1|x2) -> IDLE.
//    Each state lasts exactly (div_latched+1) cycles, timed by the bit tick.
//  - DATA: bit index 0..7 drives tx = shreg[0]; shreg shifts right on each tick.
//  - PARITY: tx = ^data (even) or ~^data (odd).
//  - STOP: tx = 1. tx_ready rises in the last cycle of the last stop bit.
//    A byte accepted then starts its start bit on the next edge, so back-to-back frames have zero idle gap.
//  - tx_ready=0 from the accept edge until that last stop cycle; tx_busy=1 from the accept edge until IDLE.
//  - Frame length: (10 + r_stop2 + P) * (r_baud_div+1) cycles, where P=1 with parity compiled in, else 0.
//  - Divisor counter is DIV_W bits and counts 0..div_latched; no wrap. div=all-ones is legal (2^DIV_W cycles/bit).
//  - tx is a register output: glitch-free, no combinational path from any input to tx.
// CONFIGURATION
//  RS232_TX_PARITY_EN defined: PARITY state is present; parity bit follows data per r_parity_odd.
//  Not defined: PARITY state and logic are removed; DATA goes straight to STOP.
//    r_parity_odd is ignored and stays a port for pin compatibility.
// STRUCTURE
//  - rs232_pkg: state enum (IDLE, START, DATA, PARITY, STOP), DATA_BITS=8,
//    frame-length helper function. Shared with the receive side.
//  - Sub-module rs232_baud_tick: DIV_W counter.
//    Clears on start pulse; emits a 1-cycle tick when count == div_latched, then restarts.
// TESTING
//  1. Reset, div=3, send 8'hA5 -> tx: 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_ready low 39 cycles.
//  2. div=0, two bytes 8'h00 and 8'hFF held valid -> 20-cycle pair, no idle between stop and next start.
//  3. r_stop2=1, div=1, byte 8'h80 -> stop high for 4 cycles; tx_ready rises in the final stop cycle.
//  4. PARITY_EN, odd, byte 8'h03 -> parity bit 1; even -> 0. Frame 11*(div+1) cycles.
//  5. Change r_baud_div 3->7 mid-frame -> current frame stays at 4 cycles/bit; next frame uses 8.
//  6. Assert reset at DATA bit 4 -> tx=1, tx_ready=1 next edge; a new byte then sends a clean full frame.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared RS232 definitions: frame states, data width and frame-length helper.
// Used by both the transmit and receive paths.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rs232_state_t;

  localparam int DATA_BITS = 8;

  function automatic int unsigned frame_cycles(
    input int unsigned div,
    input logic        stop2,
    input logic        parity
  );
    return (10 + 32'(stop2) + 32'(parity)) * (div + 1);
  endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// Bit-period timer: counts 0..div and pulses tick on the last count.
// A start pulse realigns the period to the accept edge.
module rs232_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == div);

  always_ff @(posedge clk) begin
    if (reset || start || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rs232_tx.sv
// RS232 transmitter: start, 8 data bits LSB-first, optional parity, 1/2 stop.
// Define RS232_TX_PARITY_EN to build in the parity bit.
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DIV_W-1:0]  r_baud_div,
  input  logic              r_stop2,
  input  logic              r_parity_odd,
  output logic              tx,
  output logic              tx_busy
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  rs232_state_t      state;
  logic [DATA_W-1:0] shreg;
  logic [IW-1:0]     bit_idx;
  logic              stop_idx;
  logic              stop2_l;
  logic [DIV_W-1:0]  div_l;
  logic              tick;
  logic              accept;
  logic              last_stop;

`ifdef RS232_TX_PARITY_EN
  logic par_l;
`else
  logic unused_parity;
  assign unused_parity = r_parity_odd;
`endif

  assign last_stop = (state == STOP) && (stop_idx == stop2_l);
  assign tx_ready  = (state == IDLE) || (last_stop && tick);
  assign tx_busy   = (state != IDLE);
  assign accept    = tx_valid && tx_ready;

  rs232_baud_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .div   (div_l),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      stop2_l  <= 1'b0;
      div_l    <= '0;
`ifdef RS232_TX_PARITY_EN
      par_l    <= 1'b0;
`endif
    end else if (accept) begin
      state    <= START;
      tx       <= 1'b0;
      shreg    <= tx_data;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      stop2_l  <= r_stop2;
      div_l    <= r_baud_div;
`ifdef RS232_TX_PARITY_EN
      par_l    <= r_parity_odd ^ (^tx_data);
`endif
    end else if (tick) begin
      unique case (state)
        START: begin
          state <= DATA;
          tx    <= shreg[0];
          shreg <= shreg >> 1;
        end
        DATA: begin
          if (bit_idx == LAST_BIT) begin
`ifdef RS232_TX_PARITY_EN
            state <= PARITY;
            tx    <= par_l;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        PARITY: begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: begin
          if (last_stop) begin
            state <= IDLE;
            tx    <= 1'b1;
          end else begin
            stop_idx <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx.sv
// Bench for rs232_tx: per-cycle waveform model plus directed literal checks.
// Build with +define+RS232_TX_PARITY_EN to cover the parity variant.
module tb_rs232_tx;

`ifdef RS232_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] r_baud_div = '0;
  logic        r_stop2 = 1'b0;
  logic        r_parity_odd = 1'b0;
  logic        tx;
  logic        tx_busy;

  always #5 clk = ~clk;

  rs232_tx #(
    .DIV_W(16),
    .DATA_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .r_baud_div   (r_baud_div),
    .r_stop2      (r_stop2),
    .r_parity_odd (r_parity_odd),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  typedef struct packed {
    logic tx;
    logic rdy;
    logic busy;
  } exp_t;

  int   cmp_n = 0;
  int   err_n = 0;
  exp_t q[$];
  bit   armed = 1'b0;
  bit   logging = 1'b0;
  logic log_tx[$];
  logic log_rdy[$];

  // Expected line waveform for one frame, one entry per clock cycle.
  function automatic void push_frame(logic [7:0] d, int div, logic s2, logic odd);
    logic b[$];
    int   per;
    int   len;
    exp_t e;
    per = div + 1;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (PB == 1) b.push_back(odd ^ (^d));
    b.push_back(1'b1);
    if (s2) b.push_back(1'b1);
    len = b.size() * per;
    for (int k = 0; k < len; k++) begin
      e.tx   = b[k / per];
      e.rdy  = (k == len - 1);
      e.busy = 1'b1;
      q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic mrdy;
    mrdy = 1'b0;
    if (logging) begin
      log_tx.push_back(tx);
      log_rdy.push_back(tx_ready);
    end
    if (armed) begin
      if (q.size() > 0) e = q.pop_front();
      else e = 3'b110;
      cmp_n++;
      if ({tx, tx_ready, tx_busy} !== e) begin
        err_n++;
        $display("FAIL cycle t=%0t tx/rdy/busy=%b required=%b",
                 $time, {tx, tx_ready, tx_busy}, e);
      end
      mrdy = e.rdy;
    end
    if (reset) begin
      q.delete();
      armed = 1'b1;
    end else if (armed && tx_valid && mrdy) begin
      push_frame(tx_data, int'(r_baud_div), r_stop2, r_parity_odd);
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] expv);
    cmp_n++;
    if (got !== expv) begin
      err_n++;
      $display("FAIL %s got=%h required=%h", nm, got, expv);
    end
  endtask

  task automatic send(logic [7:0] d);
    int  t;
    bit  acc;
    t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = (tx_ready === 1'b1);
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 5000) begin
        cmp_n++;
        err_n++;
        $display("FAIL accept_timeout got=none required=accept");
        break;
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (tx_busy !== 1'b0 && t < 5000);
    check("idle_reached", 32'(tx_busy), 32'd0);
    step(1);
  endtask

  task automatic check_pattern(string nm, int per, int nb,
                               logic [31:0] expv, int exp_low);
    int          s;
    int          low;
    logic [31:0] got;
    s = -1;
    foreach (log_tx[i]) if (s < 0 && log_tx[i] === 1'b0) s = i;
    got = '0;
    for (int i = 0; i < nb; i++) begin
      if (s >= 0 && s + i * per < log_tx.size())
        got[nb-1-i] = log_tx[s + i * per];
      else
        got[nb-1-i] = 1'bx;
    end
    check({nm, "_bits"}, got, expv);
    low = 0;
    foreach (log_rdy[i]) if (log_rdy[i] === 1'b0) low++;
    check({nm, "_rdy_low"}, 32'(low), 32'(exp_low));
    log_tx.delete();
    log_rdy.delete();
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_rdy", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);

    // A5 at 4 cycles/bit
    r_baud_div = 16'd3;
    logging = 1'b1;
    send(8'hA5);
    wait_idle();
    logging = 1'b0;
    if (PB == 1) check_pattern("a5_div3", 4, 11, 32'b01010010101, 43);
    else         check_pattern("a5_div3", 4, 10, 32'b0101001011, 39);

    // back-to-back at 1 cycle/bit
    r_baud_div = 16'd0;
    logging = 1'b1;
    send(8'h00);
    send(8'hFF);
    wait_idle();
    logging = 1'b0;
    if (PB == 1)
      check_pattern("b2b", 1, 22, 32'b0000000000101111111101, 20);
    else
      check_pattern("b2b", 1, 20, 32'b00000000010111111111, 18);

    // two stop bits
    r_baud_div = 16'd1;
    r_stop2 = 1'b1;
    logging = 1'b1;
    send(8'h80);
    wait_idle();
    logging = 1'b0;
    r_stop2 = 1'b0;
    if (PB == 1) check_pattern("stop2", 2, 12, 32'b000000001111, 23);
    else         check_pattern("stop2", 2, 11, 32'b00000000111, 21);

`ifdef RS232_TX_PARITY_EN
    r_baud_div = 16'd2;
    r_parity_odd = 1'b1;
    logging = 1'b1;
    send(8'h03);
    wait_idle();
    logging = 1'b0;
    check_pattern("par_odd", 3, 11, 32'b01100000011, 32);
    r_parity_odd = 1'b0;
    logging = 1'b1;
    send(8'h03);
    wait_idle();
    logging = 1'b0;
    check_pattern("par_even", 3, 11, 32'b01100000001, 32);
`endif

    // divisor change mid-frame only affects the next frame
    r_baud_div = 16'd3;
    logging = 1'b1;
    fork
      send(8'h3C);
      begin
        step(10);
        r_baud_div = 16'd7;
      end
    join
    send(8'hC3);
    wait_idle();
    logging = 1'b0;
    check_pattern("div_change", 4, 1, 32'b0, (PB == 1) ? 130 : 118);

    // reset during data bit 4
    r_baud_div = 16'd3;
    send(8'h5A);
    step(20);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_rdy", 32'(tx_ready), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    logging = 1'b1;
    send(8'h96);
    wait_idle();
    logging = 1'b0;
    if (PB == 1) check_pattern("after_abort", 4, 11, 32'b00110100101, 43);
    else         check_pattern("after_abort", 4, 10, 32'b0011010011, 39);

    // random traffic with register churn after each accept
    for (int n = 0; n < 40; n++) begin
      r_baud_div   = 16'($urandom_range(0, 5));
      r_stop2      = 1'($urandom);
      r_parity_odd = 1'($urandom);
      send(8'($urandom));
      r_baud_div   = 16'($urandom_range(0, 5));
      r_stop2      = 1'($urandom);
      r_parity_odd = 1'($urandom);
      if ($urandom_range(0, 2) == 0) step($urandom_range(1, 30));
    end
    wait_idle();
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
